// File: rtl/data_memory_write_unit.sv
// Store path into a word-addressed, byte-enabled data memory.
// A store that crosses a word boundary is split into two writes on consecutive unstalled cycles.
module data_memory_write_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        valid,
    input  logic        do_store,
    input  logic [2:0]  store_type,
    input  logic [31:0] store_addr,
    input  logic [31:0] store_data,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_en,
    output logic        mem_write_en,
    output logic        busy,
    output logic        bad_store
);

    typedef enum logic {IDLE, SECOND} state_t;

    state_t      state, next_state;
    logic [31:0] sec_addr, sec_wdata;
    logic [3:0]  sec_be;
    logic        bad_store_q;

    logic        accept, legal, crossing;
    logic [1:0]  offset;
    logic [3:0]  size_mask;
    logic [7:0]  lane_mask;
    logic [63:0] lane_data;
    logic [31:0] hi_bit_mask;

    assign offset   = store_addr[1:0];
    assign accept   = (state == IDLE) && valid && do_store && !stall && !reset;
    assign crossing = |lane_mask[7:4];

    // Enables and data are shifted through a two-word window; the upper half is the second write.
    always_comb begin
        legal       = 1'b1;
        size_mask   = '0;
        hi_bit_mask = '0;
        case (store_type)
            3'b000:  size_mask = 4'b0001;
            3'b001:  size_mask = 4'b0011;
            3'b010:  size_mask = 4'b1111;
            default: legal = 1'b0;
        endcase
        lane_mask = {4'b0000, size_mask} << offset;
        lane_data = {32'h0, store_data} << {offset, 3'b000};
        for (int unsigned i = 0; i < 4; i++) begin
            hi_bit_mask[8*i +: 8] = {8{lane_mask[4+i]}};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            sec_addr    <= '0;
            sec_wdata   <= '0;
            sec_be      <= '0;
            bad_store_q <= 1'b0;
        end else begin
            state       <= next_state;
            bad_store_q <= accept && !legal;
            if (accept && legal && crossing) begin
                sec_addr  <= {store_addr[31:2] + 30'd1, 2'b00};
                sec_wdata <= lane_data[63:32] & hi_bit_mask;
                sec_be    <= lane_mask[7:4];
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept && legal && crossing) next_state = SECOND;
            SECOND:  if (!stall) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_byte_en  = '0;
        mem_write_en = 1'b0;
        busy         = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (accept && legal) begin
                        mem_addr     = {store_addr[31:2], 2'b00};
                        mem_wdata    = lane_data[31:0];
                        mem_byte_en  = lane_mask[3:0];
                        mem_write_en = 1'b1;
                        busy         = crossing;
                    end
                end
                SECOND: begin
                    busy = stall;
                    if (!stall) begin
                        mem_addr     = sec_addr;
                        mem_wdata    = sec_wdata;
                        mem_byte_en  = sec_be;
                        mem_write_en = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bad_store = bad_store_q;

endmodule

// File: tb/tb_data_memory_write_unit.sv
// Directed bench for data_memory_write_unit: inputs change on the falling edge, outputs checked 1ns later.
module tb_data_memory_write_unit;

    logic        clock = 1'b0;
    logic        reset, stall, valid, do_store;
    logic [2:0]  store_type;
    logic [31:0] store_addr, store_data;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_byte_en;
    logic        mem_write_en, busy, bad_store;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    data_memory_write_unit dut (
        .clock(clock), .reset(reset), .stall(stall), .valid(valid),
        .do_store(do_store), .store_type(store_type), .store_addr(store_addr),
        .store_data(store_data), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_byte_en(mem_byte_en), .mem_write_en(mem_write_en), .busy(busy),
        .bad_store(bad_store)
    );

    task automatic drive(input logic r, input logic s, input logic v, input logic ds,
                         input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        reset = r; stall = s; valid = v; do_store = ds;
        store_type = t; store_addr = a; store_data = d;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h102, 32'hFFFF_FFFF);
        checks++;
        if ({mem_write_en, busy, mem_byte_en} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs we/busy/be got %b%b%b exp 000000", mem_write_en, busy, mem_byte_en);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b1, 3'b011, 32'h100, 32'h0);
        checks++;
        if (bad_store !== 1'b0) begin
            errors++;
            $display("FAIL reset_bad_store got %b exp 0", bad_store);
        end
        idle();
        checks++;
        if ({mem_write_en, busy, bad_store, mem_byte_en} !== 7'b0) begin
            errors++;
            $display("FAIL post_reset_idle got %b%b%b%b exp 0000000", mem_write_en, busy, bad_store, mem_byte_en);
        end
    endtask

    task automatic test_aligned_sw();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF);
        checks++;
        if ({mem_write_en, busy, mem_byte_en, mem_addr, mem_wdata} !== {1'b1, 1'b0, 4'b1111, 32'h100, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL aligned_sw got we=%b busy=%b be=%b addr=%h wdata=%h exp 1 0 1111 00000100 deadbeef",
                     mem_write_en, busy, mem_byte_en, mem_addr, mem_wdata);
        end
        idle();
        checks++;
        if ({mem_write_en, busy} !== 2'b00) begin
            errors++;
            $display("FAIL aligned_sw_after got we=%b busy=%b exp 0 0", mem_write_en, busy);
        end
    endtask

    task automatic test_byte_store();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 32'h203, 32'h0000_00AB);
        checks++;
        if ({mem_write_en, busy, mem_byte_en, mem_addr, mem_wdata} !== {1'b1, 1'b0, 4'b1000, 32'h200, 32'hAB00_0000}) begin
            errors++;
            $display("FAIL byte_store got we=%b busy=%b be=%b addr=%h wdata=%h exp 1 0 1000 00000200 ab000000",
                     mem_write_en, busy, mem_byte_en, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_split_sw();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 3'b010, 32'h102, 32'h1122_3344);
        checks++;
        if ({mem_write_en, busy, mem_byte_en, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b1100, 32'h100, 32'h3344_0000}) begin
            errors++;
            $display("FAIL split_sw_first got we=%b busy=%b be=%b addr=%h wdata=%h exp 1 1 1100 00000100 33440000",
                     mem_write_en, busy, mem_byte_en, mem_addr, mem_wdata);
        end
        // upstream keeps the instruction held during the second cycle
        drive(1'b0, 1'b0, 1'b1, 1'b1, 3'b010, 32'h102, 32'h1122_3344);
        checks++;
        if ({mem_write_en, busy, mem_byte_en, mem_addr, mem_wdata} !== {1'b1, 1'b0, 4'b0011, 32'h104, 32'h0000_1122}) begin
            errors++;
            $display("FAIL split_sw_second got we=%b busy=%b be=%b addr=%h wdata=%h exp 1 0 0011 00000104 00001122",
                     mem_write_en, busy, mem_byte_en, mem_addr, mem_wdata);
        end
        idle();
        checks++;
        if ({mem_write_en, busy} !== 2'b00) begin
            errors++;
            $display("FAIL split_sw_done got we=%b busy=%b exp 0 0", mem_write_en, busy);
        end
    endtask

    task automatic test_split_sh_stall();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 3'b001, 32'h3, 32'h0000_BBAA);
        checks++;
        if ({mem_write_en, busy, mem_byte_en, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b1000, 32'h0, 32'hAA00_0000}) begin
            errors++;
            $display("FAIL split_sh_first got we=%b busy=%b be=%b addr=%h wdata=%h exp 1 1 1000 00000000 aa000000",
                     mem_write_en, busy, mem_byte_en, mem_addr, mem_wdata);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 3'b001, 32'h3, 32'h0000_BBAA);
            checks++;
            if ({mem_write_en, busy} !== 2'b01) begin
                errors++;
                $display("FAIL split_sh_stalled cycle %0d got we=%b busy=%b exp 0 1", i, mem_write_en, busy);
            end
        end
        drive(1'b0, 1'b0, 1'b1, 1'b1, 3'b001, 32'h3, 32'h0000_BBAA);
        checks++;
        if ({mem_write_en, busy, mem_byte_en, mem_addr, mem_wdata} !== {1'b1, 1'b0, 4'b0001, 32'h4, 32'h0000_00BB}) begin
            errors++;
            $display("FAIL split_sh_second got we=%b busy=%b be=%b addr=%h wdata=%h exp 1 0 0001 00000004 000000bb",
                     mem_write_en, busy, mem_byte_en, mem_addr, mem_wdata);
        end
        idle();
        checks++;
        if (mem_write_en !== 1'b0) begin
            errors++;
            $display("FAIL split_sh_done got we=%b exp 0", mem_write_en);
        end
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 3'b010, 32'hFFFF_FFFD, 32'h4433_2211);
        checks++;
        if ({mem_write_en, busy, mem_byte_en, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b1110, 32'hFFFF_FFFC, 32'h3322_1100}) begin
            errors++;
            $display("FAIL wrap_first got we=%b busy=%b be=%b addr=%h wdata=%h exp 1 1 1110 fffffffc 33221100",
                     mem_write_en, busy, mem_byte_en, mem_addr, mem_wdata);
        end
        idle();
        checks++;
        if ({mem_write_en, busy, mem_byte_en, mem_addr, mem_wdata} !== {1'b1, 1'b0, 4'b0001, 32'h0, 32'h0000_0044}) begin
            errors++;
            $display("FAIL wrap_second got we=%b busy=%b be=%b addr=%h wdata=%h exp 1 0 0001 00000000 00000044",
                     mem_write_en, busy, mem_byte_en, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_illegal();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 3'b011, 32'h100, 32'h1234_5678);
        checks++;
        if ({mem_write_en, busy, bad_store} !== 3'b000) begin
            errors++;
            $display("FAIL illegal_accept got we=%b busy=%b bad=%b exp 0 0 0", mem_write_en, busy, bad_store);
        end
        idle();
        checks++;
        if ({mem_write_en, busy, bad_store} !== 3'b001) begin
            errors++;
            $display("FAIL illegal_flag got we=%b busy=%b bad=%b exp 0 0 1", mem_write_en, busy, bad_store);
        end
        idle();
        checks++;
        if (bad_store !== 1'b0) begin
            errors++;
            $display("FAIL illegal_flag_clear got bad=%b exp 0", bad_store);
        end
    endtask

    task automatic test_reset_in_second();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 3'b010, 32'h102, 32'h1122_3344);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rst2_first busy got %b exp 1", busy);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        checks++;
        if ({mem_write_en, busy} !== 2'b00) begin
            errors++;
            $display("FAIL rst2_during got we=%b busy=%b exp 0 0", mem_write_en, busy);
        end
        idle();
        checks++;
        if ({mem_write_en, busy, mem_byte_en} !== 6'b0) begin
            errors++;
            $display("FAIL rst2_after got we=%b busy=%b be=%b exp 0 0 0000", mem_write_en, busy, mem_byte_en);
        end
    endtask

    task automatic test_no_store();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 32'h100, 32'hFFFF_FFFF);
        checks++;
        if ({mem_write_en, busy, mem_byte_en, mem_addr, mem_wdata} !== 70'h0) begin
            errors++;
            $display("FAIL invalid_store got we=%b busy=%b be=%b addr=%h wdata=%h exp all 0",
                     mem_write_en, busy, mem_byte_en, mem_addr, mem_wdata);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 32'h102, 32'hFFFF_FFFF);
        checks++;
        if ({mem_write_en, busy, mem_byte_en} !== 6'b0) begin
            errors++;
            $display("FAIL non_store got we=%b busy=%b be=%b exp 0 0 0000", mem_write_en, busy, mem_byte_en);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 32'h102, 32'hFFFF_FFFF);
        checks++;
        if ({mem_write_en, busy, mem_byte_en} !== 6'b0) begin
            errors++;
            $display("FAIL stalled_idle got we=%b busy=%b be=%b exp 0 0 0000", mem_write_en, busy, mem_byte_en);
        end
        idle();
        checks++;
        if ({mem_write_en, busy} !== 2'b00) begin
            errors++;
            $display("FAIL stalled_idle_after got we=%b busy=%b exp 0 0", mem_write_en, busy);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 3'b001, 32'h202, 32'h0000_CAFE);
        checks++;
        if ({mem_write_en, busy, mem_byte_en, mem_addr, mem_wdata} !== {1'b1, 1'b0, 4'b1100, 32'h200, 32'hCAFE_0000}) begin
            errors++;
            $display("FAIL b2b_sh got we=%b busy=%b be=%b addr=%h wdata=%h exp 1 0 1100 00000200 cafe0000",
                     mem_write_en, busy, mem_byte_en, mem_addr, mem_wdata);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 32'h201, 32'h0000_005A);
        checks++;
        if ({mem_write_en, busy, mem_byte_en, mem_addr, mem_wdata} !== {1'b1, 1'b0, 4'b0010, 32'h200, 32'h0000_5A00}) begin
            errors++;
            $display("FAIL b2b_sb got we=%b busy=%b be=%b addr=%h wdata=%h exp 1 0 0010 00000200 00005a00",
                     mem_write_en, busy, mem_byte_en, mem_addr, mem_wdata);
        end
        idle();
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; valid = 1'b0; do_store = 1'b0;
        store_type = 3'b000; store_addr = '0; store_data = '0;
        test_reset();
        test_aligned_sw();
        test_byte_store();
        test_split_sw();
        test_split_sh_stall();
        test_wrap();
        test_illegal();
        test_reset_in_second();
        test_no_store();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
